// File: rtl/sa_input_skewer.sv
`default_nettype none
// ============================================================================
//  Module   : sa_input_skewer
//  Brief    : Buffers row vectors from a valid/ready stream and feeds the
//             systolic core with lane i delayed i cycles, framing each tile
//             with a drain phase and a tile_done pulse.
//             Optional macro SA_SKEW_STALL_EN adds a stall input.
//  Revision : 1.0  initial release
// ============================================================================
module sa_input_skewer #(
    parameter int ROWS   = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
`ifdef SA_SKEW_STALL_EN
    input  logic                   stall,
`endif
    input  logic [ROWS*DATA_W-1:0] in_vec,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ROWS*DATA_W-1:0] aout,
    output logic [ROWS-1:0]        avalid,
    output logic                   busy,
    output logic                   tile_done
);

    localparam int C_VEC_W = ROWS * DATA_W;
    localparam int C_AW    = $clog2(DEPTH);
    localparam int C_DC_W  = (ROWS > 2) ? $clog2(ROWS - 1) : 1;

    localparam logic [C_AW:0]     C_DEPTH   = (C_AW + 1)'(DEPTH);
    localparam logic [C_DC_W-1:0] C_DC_TERM = C_DC_W'((ROWS > 1) ? ROWS - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    logic w_stall;
`ifdef SA_SKEW_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [C_VEC_W-1:0] r_mem_vec [DEPTH];
    logic [DEPTH-1:0]   r_mem_last;
    logic [C_AW-1:0]    r_wr_ptr;
    logic [C_AW-1:0]    r_rd_ptr;
    logic [C_AW:0]      r_count;
    logic [C_AW:0]      w_count_nxt;
    logic               r_in_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [C_VEC_W-1:0] w_head_vec;
    logic               w_head_last;

    assign w_push      = in_valid & r_in_ready;
    assign w_empty     = (r_count == '0);
    assign w_head_vec  = r_mem_vec[r_rd_ptr];
    assign w_head_last = r_mem_last[r_rd_ptr];
    assign in_ready    = r_in_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_vec[r_wr_ptr]  <= in_vec;
            r_mem_last[r_wr_ptr] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != C_DEPTH);
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: IDLE and STREAM both pop whenever data is waiting; the
    // only difference is whether a tile is currently open (busy).
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [C_DC_W-1:0] r_drain_cnt;
    logic [C_DC_W-1:0] w_drain_cnt_nxt;
    logic              w_tile_done_nxt;
    logic              r_tile_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_tile_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_tile_done <= w_tile_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_pop           = 1'b0;
        w_tile_done_nxt = 1'b0;
        if (!w_stall) begin
            case (r_state)
                ST_IDLE, ST_STREAM: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_last) begin
                            // A single lane has nothing to drain: done follows the pop directly.
                            if (ROWS == 1) begin
                                w_state_nxt     = ST_IDLE;
                                w_tile_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt     = ST_DRAIN;
                                w_drain_cnt_nxt = '0;
                            end
                        end else begin
                            w_state_nxt = ST_STREAM;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == C_DC_TERM) begin
                        w_state_nxt     = ST_IDLE;
                        w_drain_cnt_nxt = '0;
                        w_tile_done_nxt = 1'b1;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign tile_done = r_tile_done;
    assign busy      = (r_state != ST_IDLE) || !w_empty || r_tile_done;

    // ------------------------------------------------------------------
    // Skew pipeline: lane i is i+1 stages deep; bubbles carry zero data
    // ------------------------------------------------------------------
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [DATA_W-1:0] r_sd [i+1];
        logic [i:0]        r_sv;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s <= i; s++) begin
                    r_sd[s] <= '0;
                end
                r_sv <= '0;
            end else if (!w_stall) begin
                r_sd[0] <= w_pop ? w_head_vec[i*DATA_W +: DATA_W] : '0;
                r_sv[0] <= w_pop;
                for (int s = 1; s <= i; s++) begin
                    r_sd[s] <= r_sd[s-1];
                    r_sv[s] <= r_sv[s-1];
                end
            end
        end

        assign aout[i*DATA_W +: DATA_W] = r_sd[i];
        assign avalid[i]                = r_sv[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_input_skewer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sa_input_skewer
//  Brief    : Scoreboard bench for sa_input_skewer; a tile-level issue model
//             predicts every lane, tile_done, busy and in_ready each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sa_input_skewer;

    localparam int ROWS   = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int VW     = ROWS * DATA_W;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic          in_last  = 1'b0;
    logic          in_valid = 1'b0;
    logic          stall    = 1'b0;
    logic [VW-1:0] in_vec   = '0;
    logic          in_ready;
    logic [VW-1:0] aout;
    logic [ROWS-1:0] avalid;
    logic          busy;
    logic          tile_done;

    int checks   = 0;
    int failures = 0;
    int force_stall_n = 0;
    bit stall_rand    = 1'b0;

    typedef struct packed {
        logic          v;
        logic          last;
        logic [VW-1:0] d;
    } slot_t;

    slot_t exp_q[$];

    always #5 clk = ~clk;

    sa_input_skewer #(.ROWS(ROWS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef SA_SKEW_STALL_EN
        .stall     (stall),
`endif
        .in_vec    (in_vec),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aout      (aout),
        .avalid    (avalid),
        .busy      (busy),
        .tile_done (tile_done)
    );

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: tile-level model of occupancy, issue slots and drain time
    // ------------------------------------------------------------------
    initial begin : monitor
        slot_t           hist [ROWS];
        slot_t           s;
        int              cnt;
        int              drain_rem;
        bit              open_t;
        bit              td_exp;
        bit              td_nxt;
        bit              do_push;
        logic [VW-1:0]   e_aout;
        logic [ROWS-1:0] e_av;
        logic            e_busy;
        cnt = 0; drain_rem = 0; open_t = 0; td_exp = 0;
        for (int i = 0; i < ROWS; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                cnt = 0; drain_rem = 0; open_t = 0; td_exp = 0;
                for (int i = 0; i < ROWS; i++) hist[i] = '0;
                exp_q.delete();
                chk("rst_in_ready", VW'(in_ready), VW'(1));
                chk("rst_aout", aout, '0);
                chk("rst_avalid", VW'(avalid), '0);
                chk("rst_busy", VW'(busy), '0);
                chk("rst_tile_done", VW'(tile_done), '0);
            end else begin
                for (int i = 0; i < ROWS; i++) begin
                    e_av[i] = hist[i].v;
                    e_aout[i*DATA_W +: DATA_W] = hist[i].v ? hist[i].d[i*DATA_W +: DATA_W] : '0;
                end
                e_busy = open_t || (drain_rem > 0) || (cnt > 0) || td_exp;
                chk("avalid", VW'(avalid), VW'(e_av));
                chk("aout", aout, e_aout);
                chk("tile_done", VW'(tile_done), VW'(td_exp));
                chk("in_ready", VW'(in_ready), VW'(cnt < DEPTH));
                chk("busy", VW'(busy), VW'(e_busy));

                // Predict the coming edge.
                do_push = in_valid && in_ready;
                td_nxt  = 1'b0;
                if (!stall) begin
                    s = '0;
                    if (drain_rem == 0 && cnt > 0) begin
                        if (exp_q.size() > 0) s = exp_q.pop_front();
                        cnt--;
                        if (s.last) begin
                            open_t    = 1'b0;
                            drain_rem = ROWS - 1;
                            if (ROWS == 1) td_nxt = 1'b1;
                        end else begin
                            open_t = 1'b1;
                        end
                    end else if (drain_rem > 0) begin
                        drain_rem--;
                        if (drain_rem == 0) td_nxt = 1'b1;
                    end
                    for (int i = ROWS - 1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = s;
                end
                if (do_push) cnt++;
                td_exp = td_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic upd_stall();
`ifdef SA_SKEW_STALL_EN
        if (force_stall_n > 0) begin
            stall = 1'b1;
            force_stall_n--;
        end else begin
            stall = stall_rand && ($urandom_range(0, 5) == 0);
        end
`endif
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW; i += 32) v = {v, $urandom()};
        return v;
    endfunction

    task automatic send(input logic [VW-1:0] v, input logic l);
        slot_t e;
        int    waited;
        waited = 0;
        @(posedge clk); #2;
        in_valid = 1'b1; in_vec = v; in_last = l;
        upd_stall();
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.v = 1'b1; e.last = l; e.d = v;
                exp_q.push_back(e);
                break;
            end
            waited++;
            if (waited > 100) begin
                checks++; failures++;
                $display("FAIL send_timeout t=%0t actual=in_ready_low required=accept", $time);
                in_valid = 1'b0;
                break;
            end
            @(posedge clk); #2;
            upd_stall();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            in_valid = 1'b0; in_last = 1'b0; in_vec = rand_vec();
            upd_stall();
        end
    endtask

    initial begin : driver
        logic [VW-1:0] v;
        int len;
        // Reset with a producer offering data: nothing may be captured.
        in_valid = 1'b1; in_vec = rand_vec();
        repeat (4) @(posedge clk);
        #2 in_valid = 1'b0; rstn = 1'b1;

        // Single tile: lane i of vector k = k*16+i.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < ROWS; i++) v[i*DATA_W +: DATA_W] = DATA_W'(k * 16 + i);
            send(v, k == 3);
        end
        idle(20);

        // Back-to-back burst of 6 behind a draining tile.
        send(rand_vec(), 1'b0);
        send(rand_vec(), 1'b1);
        for (int k = 0; k < 6; k++) send(rand_vec(), k == 5);
        idle(30);

        // Two-cycle bubble mid-tile.
        send(rand_vec(), 1'b0);
        send(rand_vec(), 1'b0);
        idle(2);
        send(rand_vec(), 1'b0);
        send(rand_vec(), 1'b1);
        idle(20);

        // Reset three cycles after the last pop, during DRAIN.
        send(rand_vec(), 1'b1);
        idle(4);
        @(posedge clk); #2 rstn = 1'b0;
        @(posedge clk); #2 rstn = 1'b1;
        idle(3);
        for (int k = 0; k < 3; k++) send(rand_vec(), k == 2);
        idle(20);

`ifdef SA_SKEW_STALL_EN
        // Three-cycle stall mid-stream while the producer keeps pushing.
        send(rand_vec(), 1'b0);
        send(rand_vec(), 1'b0);
        force_stall_n = 3;
        for (int k = 0; k < 4; k++) send(rand_vec(), k == 3);
        idle(25);
        stall_rand = 1'b1;
`endif

        // Random tiles with random gaps.
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(rand_vec(), k == len - 1);
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 10));
        end
        stall_rand = 1'b0;
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
